// File: rtl/qam_pkg.sv
// Shared QAM link definitions: symbol width, sign-bit positions and the P2S state encoding.
package qam_pkg;

  localparam int SYM_W   = 2;
  localparam int SIN_IDX = 1;
  localparam int COS_IDX = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } p2s_state_t;

endpackage

// File: rtl/sym_fifo.sv
// Small synchronous symbol FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module sym_fifo
  import qam_pkg::*;
#(
  parameter  int WIDTH = SYM_W,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/p2s.sv
// Demodulator-side parallel-to-serial converter: buffers 2-bit symbols and emits sin bit then
// cos bit, each held BIT_PERIOD cycles and flagged by a one-cycle data_change strobe.
module p2s
  import qam_pkg::*;
#(
  parameter int BIT_PERIOD = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] elojel_sin_cos,
  output logic             sym_ready,
  output logic             adat_ki_S,
  output logic             data_change,
  output logic             busy
);

  localparam int              CNTW = $clog2(BIT_PERIOD);
  localparam int              CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(BIT_PERIOD - 1);

  p2s_state_t       state;
  logic [CNTW-1:0]  cnt;
  logic             lo_bit;
  logic [SYM_W-1:0] rd_data;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             last;
  logic             push_en;
  logic             pop_en;
  logic             to_idle;

  sym_fifo #(
    .WIDTH (SYM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_en),
    .wr_data (elojel_sin_cos),
    .pop     (pop_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Pops happen only from IDLE or on the final SEND_LO cycle, which gives the gapless turnaround.
  always_comb begin
    last       = (cnt == LAST);
    push_en    = sym_valid && sym_ready && !full;
    pop_en     = !empty && ((state == IDLE) || ((state == SEND_LO) && last));
    count_next = count;
    if (push_en && !pop_en)      count_next = count + CW'(1);
    else if (!push_en && pop_en) count_next = count - CW'(1);
    to_idle    = !pop_en && ((state == IDLE) || ((state == SEND_LO) && last));
  end

  // sym_ready looks only at the next FIFO count, never at a same-cycle pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      sym_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sym_ready <= (count_next != CW'(FIFO_DEPTH));
      busy      <= !to_idle || (count_next != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lo_bit      <= 1'b0;
      adat_ki_S   <= 1'b0;
      data_change <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt         <= '0;
          data_change <= 1'b0;
          if (pop_en) begin
            state       <= SEND_HI;
            lo_bit      <= rd_data[COS_IDX];
            adat_ki_S   <= rd_data[SIN_IDX];
            data_change <= 1'b1;
          end
        end
        SEND_HI: begin
          if (last) begin
            state       <= SEND_LO;
            cnt         <= '0;
            adat_ki_S   <= lo_bit;
            data_change <= 1'b1;
          end else begin
            cnt         <= cnt + CNTW'(1);
            data_change <= 1'b0;
          end
        end
        SEND_LO: begin
          if (last) begin
            cnt <= '0;
            if (pop_en) begin
              state       <= SEND_HI;
              lo_bit      <= rd_data[COS_IDX];
              adat_ki_S   <= rd_data[SIN_IDX];
              data_change <= 1'b1;
            end else begin
              state       <= IDLE;
              data_change <= 1'b0;
            end
          end else begin
            cnt         <= cnt + CNTW'(1);
            data_change <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          data_change <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/p2s.md
# p2s

Parallel-to-serial converter on the demodulator side of the QAM link, the counterpart of the transmit-side S2P. It accepts decided 2-bit symbols (sin/cos sign pair, `elojel_sin_cos`) through a valid/ready handshake and buffers them in a small FIFO. It then re-emits each symbol as two serial bits on `adat_ki_S`, each held for a fixed bit period and marked by a one-cycle `data_change` strobe. Bit order mirrors S2P packing, so a round trip through S2P and this block reproduces the original serial stream.

## Interface
- `BIT_PERIOD`, default 4: clock cycles each output bit is held; legal range 2–255.
- `FIFO_DEPTH`, default 2: symbol buffer entries; power of two, at least 2.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `sym_valid` in 1: `elojel_sin_cos` holds a valid symbol.
- `elojel_sin_cos` in 2: [1] = sin sign (first bit out), [0] = cos sign (second bit out).
- `sym_ready` out 1: block can accept a symbol this cycle.
- `adat_ki_S` out 1: serial data out.
- `data_change` out 1: one-cycle pulse in the first cycle of every new bit.
- `busy` out 1: high while the FSM is not IDLE or the FIFO is non-empty.

## Operation
- Handshake: a symbol transfers on a rising edge where `sym_valid && sym_ready`. Data must stay stable while valid is high and ready is low.
- `sym_ready` = FIFO not full, registered from the FIFO count only. It does not depend on a same-cycle pop, so there is no push into a full FIFO even while a pop occurs.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop one symbol and go to SEND_HI.
  - SEND_HI: drive the popped [1] bit; hold for BIT_PERIOD cycles, then go to SEND_LO.
  - SEND_LO: drive the popped [0] bit; hold for BIT_PERIOD cycles.
  - On the last SEND_LO cycle: if the FIFO is non-empty, pop and go directly to SEND_HI with no gap; otherwise go to IDLE.
- Bit counter: counts 0..BIT_PERIOD-1, cleared on every state entry, width $clog2(BIT_PERIOD).
- `data_change` = 1 exactly when the counter is 0 in SEND_HI or SEND_LO.
- In IDLE, `adat_ki_S` holds the last driven bit and `data_change` = 0.
- Simultaneous push and pop: both take effect; count is unchanged.
- Reset values: `adat_ki_S`=0, `data_change`=0, `sym_ready`=0 while reset is high and 1 on the first cycle after release, `busy`=0. FIFO is emptied and the FSM returns to IDLE.
- Reset mid-symbol: the partial symbol and all buffered symbols are discarded; there are no further `data_change` pulses.

## Timing
- Latency, idle case: handshake at edge N gives FIFO write at N and pop at N+1. `adat_ki_S` carries bit [1] and `data_change`=1 in the cycle after edge N+1.
- Symbol duration: 2·BIT_PERIOD cycles.
- Sustained throughput: one symbol per 2·BIT_PERIOD cycles, back-to-back with no idle cycle while the FIFO is non-empty.
- `data_change` spacing: exactly BIT_PERIOD cycles during continuous traffic.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `qam_pkg`:
  - `SYM_W`=2;
  - FSM state enum `p2s_state_t` {IDLE, SEND_HI, SEND_LO};
  - symbol bit index constants `SIN_IDX`=1, `COS_IDX`=0, which S2P also uses.
- Sub-module `sym_fifo`: synchronous FIFO with parameters width SYM_W and depth FIFO_DEPTH, ports push/pop/full/empty/count. Pointer wrap is modulo FIFO_DEPTH.
- The FSM, bit counter and output registers live in `p2s`.

## Test plan
- Single symbol, BIT_PERIOD=4: push 2'b10 into an idle block → `adat_ki_S`=1 for 4 cycles then 0 for 4 cycles. `data_change` pulses at cycle offsets 0 and 4 after the first-bit cycle; `busy` falls after cycle 8.
- Back-to-back: push 2'b01, 2'b11, 2'b00 with `sym_valid` held high → serial 0,1,1,1,0,0. Pulses are exactly 4 cycles apart with no gap; `sym_ready` drops while the FIFO is full.
- Backpressure: hold `sym_valid` with 2'b11 while full → no push until `sym_ready`=1. The symbol is accepted exactly once and appears once in the output.
- Reset mid-symbol: assert reset during the SEND_HI of 2'b10 with one more symbol queued → next cycle all outputs are 0, nothing further is emitted, and `sym_ready`=1 after release.
- Loopback: drive 64 random bits through S2P into `p2s` (BIT_PERIOD=4) → `adat_ki_S` sampled at `data_change` equals the input sequence, in order.
- BIT_PERIOD=2 corner: 4 consecutive symbols → strobe every 2 cycles and no bit dropped at the SEND_LO→SEND_HI turnaround.
